// File: rtl/fifo_sync_if.sv
// Producer/consumer side bundle for fifo_sync: push/pop handshake,
// show-ahead data, occupancy and status flags.
interface fifo_sync_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             write;
  logic [WIDTH-1:0] din;
  logic             read;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  // Producer/consumer view: drives requests and data, observes status.
  modport master (
    output write, din, read,
    input  dout, full, empty, count, almost_full, almost_empty,
           overflow, underflow
  );

  // FIFO view: accepts requests and data, reports status.
  modport slave (
    input  write, din, read,
    output dout, full, empty, count, almost_full, almost_empty,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_sync.sv
// Parametrised single-clock show-ahead FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds and sticky
// overflow/underflow error flags.
module fifo_sync #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AW       = 2,
  parameter int AF_LEVEL = 3,
  parameter int AE_LEVEL = 1
) (
  input  logic           clk,
  input  logic           clr,
  fifo_sync_if.slave     bus
);

  // Thresholds sized to the count register so every compare is width-matched.
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             full_s;
  logic             empty_s;
  logic             wr_en_s;
  logic             rd_en_s;
  logic             drop_s;
  logic             ignore_s;
  logic [AW:0]      count_nxt_s;
  logic [WIDTH-1:0] dout_s;

  // Status decode from occupancy; full and empty share the same count compare.
  always_comb begin
    full_s  = (count_r == DEPTH_C);
    empty_s = (count_r == {(AW+1){1'b0}});
  end

  // Accept logic: a full FIFO still takes a write if a pop frees the slot,
  // and an empty FIFO never pops (no same-cycle bypass).
  always_comb begin
    wr_en_s  = bus.write & (~full_s | bus.read);
    rd_en_s  = bus.read & ~empty_s;
    drop_s   = bus.write & full_s & ~bus.read;
    ignore_s = bus.read & empty_s;
  end

  // Next occupancy: only an unbalanced push or pop moves the count.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_en_s, rd_en_s})
      2'b10:   count_nxt_s = count_r + ONE_C;
      2'b01:   count_nxt_s = count_r - ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, count and sticky error state; clr wins over any request.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {(AW+1){1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      count_r <= count_nxt_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (ignore_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  // Storage is never cleared; a write coinciding with clr is discarded.
  always_ff @(posedge clk) begin
    if (wr_en_s && !clr) begin
      mem_r[wr_ptr_r] <= bus.din;
    end
  end

  // Show-ahead head word, forced to zero while the FIFO holds nothing.
  always_comb begin
    if (empty_s) begin
      dout_s = {WIDTH{1'b0}};
    end else begin
      dout_s = mem_r[rd_ptr_r];
    end
  end

  // Drive the bundle outputs from the decoded state.
  always_comb begin
    bus.dout         = dout_s;
    bus.full         = full_s;
    bus.empty        = empty_s;
    bus.count        = count_r;
    bus.almost_full  = (count_r >= AF_C);
    bus.almost_empty = (count_r <= AE_C);
    bus.overflow     = overflow_r;
    bus.underflow    = underflow_r;
  end

endmodule
